data_mem_arbiter: RTL
=====================

# data_mem_arbiter

Two-port round-robin arbiter that shares the single-ported data memory (15-bit word address, 16-bit data) between two requesters: port 0 (CPU data side) and port 1 (screen/DMA engine). It sits between the requesters and the data memory's load/adr/d_in/d_out port and sequences one access at a time through a req/ack handshake. All outputs are registered. Reads are captured from the memory's combinational output; writes commit at the clock edge.

## Interface
- ADDR_W, 15, memory word-address width
- DATA_W, 16, memory data width

- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- r0_req  in  1  port 0 access request, held until r0_ack
- r0_we  in  1  port 0: 1 = write, 0 = read
- r0_adr  in  ADDR_W  port 0 word address
- r0_wdata  in  DATA_W  port 0 write data
- r0_ack  out  1  port 0 one-cycle completion pulse
- r0_rdata  out  DATA_W  port 0 read data, valid while r0_ack is high, held afterward
- r1_req, r1_we, r1_adr, r1_wdata, r1_ack, r1_rdata  same as port 0, for port 1
- mem_load  out  1  memory write enable
- mem_adr  out  ADDR_W  memory address
- mem_d_in  out  DATA_W  memory write data
- mem_d_out  in  DATA_W  memory read data, combinational from mem_adr
- busy  out  1  high while in SERVE

## Operation
- FSM has two states: IDLE and SERVE. Reset state is IDLE.
- IDLE:
  - At a rising edge where any req is high, pick a winner, latch its we/adr/wdata into mem_load/mem_adr/mem_d_in and record the grant id. Go to SERVE.
  - If no req is high, stay in IDLE with mem_load=0; mem_adr and mem_d_in hold their values.
- Arbitration: round robin using a register `last`, the id of the most recent grant.
  - If only one req is high, that port wins.
  - If both are high, the port != last wins.
  - `last` updates on each grant. Reset value of `last` is 1, so port 0 wins the first tie.
- SERVE lasts exactly one cycle. At its closing edge:
  - mem_load=1 writes commit in memory.
  - For a read, mem_d_out is captured into rX_rdata of the granted port.
  - rX_ack of the granted port goes to 1 for one cycle.
  - mem_load goes to 0 and the FSM returns to IDLE.
- rX_rdata updates only on reads for that port. On writes and on the other port's accesses it holds its value.
- Requester rules:
  - req, we, adr and wdata stay stable from req assertion until ack is seen.
  - In the cycle ack is high, the requester either drops req or presents its next command with req held high. That cycle's req is sampled as a new request.
- Requests are never lost or reordered per port. Each ack corresponds to exactly one grant.
- While in SERVE, req inputs are ignored. The ungranted port waits.
- Reset, including mid-SERVE, immediately forces:
  - state=IDLE, last=1
  - mem_load=0, mem_adr=0, mem_d_in=0
  - r0_ack=r1_ack=0, r0_rdata=r1_rdata=0, busy=0
  - Any in-flight access is aborted: no ack is issued and the write is not performed after reset is asserted.

## Timing
- Reset values of all outputs are 0.
- Latency for a single requester: req high in cycle T → mem_load/mem_adr driven in T+1 (busy=1) → ack and rdata in T+2.
- Throughput is one access per 2 cycles. With both ports requesting continuously, grants alternate 0,1,0,1,… and each port gets one access per 4 cycles.
- Worst-case wait for a port from req to grant is 2 cycles: one SERVE of the other port plus one IDLE.
- mem_load is high only during SERVE, and only for writes.
- At most one ack is high in any cycle. Both acks are low while busy=1.

## Test plan
- Reset then single read: mem[0x0010]=0xBEEF, r0 read adr 0x0010 → r0_ack pulses 2 cycles after req sample, r0_rdata=0xBEEF, r1_ack stays 0.
- Write then read back on port 1: write 0x1234 to adr 0x4000 (screen base), then read 0x4000 → mem_load high exactly one cycle with mem_adr=0x4000, mem_d_in=0x1234; read returns 0x1234; r1_rdata unchanged by the write ack.
- Simultaneous requests held continuously for 8 accesses → grants alternate 0,1,0,1…, the first grant after reset goes to port 0, no ack is dropped or duplicated, and both acks are never high together.
- Back-to-back on one port: r0 keeps req high in its ack cycle with a new adr → new grant at that edge, next ack 2 cycles later; r1 requests mid-sequence → r1 is served next.
- Reset asserted asynchronously mid-SERVE of a write to 0x0005 (old value 0x0000) → mem_load drops immediately, no ack, mem[0x0005] still 0x0000, FSM in IDLE, next tie goes to port 0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-ported data memory
// between the CPU data side (port 0) and the screen/DMA engine (port 1).
module data_mem_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_adr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_adr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_d_in,
  input  logic [DATA_W-1:0] mem_d_out,
  output logic              busy
);

  typedef enum logic {IDLE, SERVE} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              load_q, load_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic              win;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    load_d  = 1'b0;
    adr_d   = adr_q;
    din_d   = din_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    // on a tie the port that did not win last time goes next
    win = (r0_req & r1_req) ? ~last_q : r1_req;
    unique case (state_q)
      IDLE: begin
        if (r0_req | r1_req) begin
          state_d = SERVE;
          gnt_d   = win;
          last_d  = win;
          load_d  = win ? r1_we : r0_we;
          adr_d   = win ? r1_adr : r0_adr;
          din_d   = win ? r1_wdata : r0_wdata;
        end
      end
      SERVE: begin
        state_d = IDLE;
        if (gnt_q) begin
          ack1_d = 1'b1;
          if (!load_q) rd1_d = mem_d_out;
        end else begin
          ack0_d = 1'b1;
          if (!load_q) rd0_d = mem_d_out;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      load_q  <= 1'b0;
      adr_q   <= '0;
      din_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      load_q  <= load_d;
      adr_q   <= adr_d;
      din_q   <= din_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  assign r0_ack   = ack0_q;
  assign r1_ack   = ack1_q;
  assign r0_rdata = rd0_q;
  assign r1_rdata = rd1_q;
  assign mem_load = load_q;
  assign mem_adr  = adr_q;
  assign mem_d_in = din_q;
  assign busy     = (state_q == SERVE);

endmodule
